snoop_bus_arbiter: RTL
======================

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

Interface
REQ-001 NUM_CORES, default 2, number of requesting caches; legal range 2..16.
REQ-002 ADDR_W, default 8, bus address width in bits.
REQ-003 IDW, derived as $clog2(NUM_CORES), not overridable; width of src_id.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 cmd_in[NUM_CORES]  input  bus_request each  per-core request; No_OP means idle.
REQ-007 addr_in[NUM_CORES]  input  ADDR_W each  per-core request address.
REQ-008 done_in  input  1  transaction complete; from memory/snoop responders.
REQ-009 cmd_out  output  bus_request  broadcast command.
REQ-010 addr_out  output  ADDR_W  broadcast address.
REQ-011 src_id  output  IDW  index of current bus owner.
REQ-012 bus_valid  output  1  one-cycle strobe marking a new broadcast.
REQ-013 gnt  output  NUM_CORES  one-hot owner indication.
REQ-014 ack  output  NUM_CORES  one-hot, one-cycle completion pulse to owner.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, BCAST, WAIT, DONE; all outputs registered.
REQ-017 IDLE: if any cmd_in != No_OP, winner's cmd, addr and index SHALL be latched at the edge and state SHALL go to BCAST; else stay IDLE.
REQ-018 IDLE outputs SHALL be: cmd_out=No_OP, addr_out=0, src_id=0, gnt=0, ack=0, bus_valid=0.
REQ-019 BCAST SHALL last exactly one cycle with bus_valid=1, gnt[winner]=1, latched cmd/addr/id on outputs; next state WAIT.
REQ-020 WAIT SHALL hold cmd_out, addr_out, src_id, gnt unchanged with bus_valid=0 until done_in is sampled high, then go to DONE.
REQ-021 done_in SHALL be ignored in IDLE, BCAST and DONE.
REQ-022 DONE SHALL last one cycle with ack[winner]=1, gnt=0, cmd_out=No_OP; no arbitration in DONE; next state IDLE.
REQ-023 A requester SHALL hold cmd_in/addr_in stable until it samples ack, and drive No_OP from that edge; changes to cmd_in during BCAST/WAIT SHALL not affect latched values.
REQ-024 Latency: request sampled at edge k -> bus_valid high in cycle k+1; done_in sampled at edge m -> ack high in cycle m+1; minimum transaction 4 cycles.
REQ-025 Simultaneous requests SHALL select exactly one winner per Configuration section; losers stay pending with gnt=0.
REQ-026 Winner selection SHALL wrap modulo NUM_CORES.

Reset
REQ-027 rst high SHALL immediately force state IDLE and all outputs to REQ-018 values, busy=0, round-robin pointer=0, latched cmd/addr/id cleared, including mid-transaction.
REQ-028 First arbitration SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN defined: rotating priority; search starts at pointer, pointer := winner+1 mod NUM_CORES on the DONE->IDLE transition.
REQ-030 ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; no pointer register exists.

Structure
REQ-031 bus_request enum (No_OP=00, BusRd=01, BusRdX=10, BusUpgr=11) and new arb state enum SHALL live in package mesi_types.
REQ-032 Winner selection SHALL be one combinational sub-module rr_arbiter (request vector + base index -> one-hot grant + index valid); fixed priority uses base=0.
REQ-033 Elaboration SHALL fail for NUM_CORES outside 2..16.

Verification
REQ-034 Single request: core1 BusRd addr 0x3C -> next cycle bus_valid=1, cmd_out=BusRd, addr_out=0x3C, src_id=1, gnt=0b10; done_in 3 cycles later -> ack=0b10 for one cycle, then IDLE.
REQ-035 Contention, RR on: cores 0 and 1 request continuously -> owners alternate 0,1,0,1 over 4 transactions; RR off -> core0 wins all while it keeps requesting.
REQ-036 NUM_CORES=4, ADDR_W=16, all cores request BusRdX -> grant order 0,1,2,3,0 (RR on), addr_out matches each owner's address.
REQ-037 Early done_in: done_in high during BCAST only -> ignored, stays WAIT until next done_in.
REQ-038 Reset mid-WAIT: rst pulse -> outputs at reset values immediately; pending core0 BusUpgr re-granted with bus_valid in first cycle after first edge post-reset.
REQ-039 Input churn: cmd_in/addr_in of owner change in WAIT -> cmd_out/addr_out unchanged until DONE.

Source files
------------

// File: rtl/mesi_types.sv
// Shared snoop-bus types: bus command encoding and arbiter FSM states.
package mesi_types;

  typedef enum logic [1:0] {
    No_OP   = 2'b00,
    BusRd   = 2'b01,
    BusRdX  = 2'b10,
    BusUpgr = 2'b11
  } bus_request;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_BCAST = 2'b01,
    ARB_WAIT  = 2'b10,
    ARB_DONE  = 2'b11
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first active request at or after base_i, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N   = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] base_i,
  output logic [N-1:0]  gnt_c_o,
  output logic [IW-1:0] idx_c_o,
  output logic          valid_c_o
);

  int unsigned pos;

  always_comb begin
    gnt_c_o   = '0;
    idx_c_o   = '0;
    valid_c_o = 1'b0;
    pos       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(base_i) + i) % N;
      if (!valid_c_o && req_i[IW'(pos)]) begin
        gnt_c_o[IW'(pos)] = 1'b1;
        idx_c_o           = IW'(pos);
        valid_c_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoop bus arbiter: one owner per transaction, IDLE -> BCAST -> WAIT -> DONE, all outputs registered.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority, lowest index wins.
module snoop_bus_arbiter
  import mesi_types::*;
#(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned ADDR_W    = 8,
  localparam int unsigned IDW      = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  bus_request           cmd_in  [NUM_CORES],
  input  logic [ADDR_W-1:0]    addr_in [NUM_CORES],
  input  logic                 done_in,
  output bus_request           cmd_out,
  output logic [ADDR_W-1:0]    addr_out,
  output logic [IDW-1:0]       src_id,
  output logic                 bus_valid,
  output logic [NUM_CORES-1:0] gnt,
  output logic [NUM_CORES-1:0] ack,
  output logic                 busy
);

  if (NUM_CORES < 2 || NUM_CORES > 16) begin : g_bad_cfg
    $error("snoop_bus_arbiter: NUM_CORES must be within 2..16");
  end

  arb_state_e           state_q, state_d;
  bus_request           win_cmd_q, win_cmd_d;
  logic [ADDR_W-1:0]    win_addr_q, win_addr_d;
  logic [IDW-1:0]       win_id_q, win_id_d;
  logic [NUM_CORES-1:0] owner_oh;
  logic [NUM_CORES-1:0] req;
  logic [IDW-1:0]       base;
  logic [NUM_CORES-1:0] arb_gnt;
  logic [IDW-1:0]       arb_idx;
  logic                 arb_valid;

  bus_request           cmd_out_d;
  logic [ADDR_W-1:0]    addr_out_d;
  logic [IDW-1:0]       src_id_d;
  logic                 bus_valid_d;
  logic [NUM_CORES-1:0] gnt_d;
  logic [NUM_CORES-1:0] ack_d;
  logic                 busy_d;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      req[i] = (cmd_in[i] != No_OP);
    end
  end

  assign owner_oh = NUM_CORES'(1) << win_id_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  // Priority rotates past the owner only once its transaction has fully retired.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ARB_DONE) begin
      ptr_d = (32'(win_id_q) == NUM_CORES - 1) ? '0 : win_id_q + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign base = ptr_q;
`else
  assign base = '0;
`endif

  rr_arbiter #(.N(NUM_CORES)) u_rr_arbiter (
    .req_i     (req),
    .base_i    (base),
    .gnt_c_o   (arb_gnt),
    .idx_c_o   (arb_idx),
    .valid_c_o (arb_valid)
  );

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    win_cmd_d   = win_cmd_q;
    win_addr_d  = win_addr_q;
    win_id_d    = win_id_q;
    cmd_out_d   = No_OP;
    addr_out_d  = '0;
    src_id_d    = '0;
    bus_valid_d = 1'b0;
    gnt_d       = '0;
    ack_d       = '0;
    case (state_q)
      ARB_IDLE: begin
        if (arb_valid) begin
          state_d     = ARB_BCAST;
          win_cmd_d   = cmd_in[arb_idx];
          win_addr_d  = addr_in[arb_idx];
          win_id_d    = arb_idx;
          cmd_out_d   = cmd_in[arb_idx];
          addr_out_d  = addr_in[arb_idx];
          src_id_d    = arb_idx;
          gnt_d       = arb_gnt;
          bus_valid_d = 1'b1;
        end
      end
      ARB_BCAST: begin
        state_d    = ARB_WAIT;
        cmd_out_d  = win_cmd_q;
        addr_out_d = win_addr_q;
        src_id_d   = win_id_q;
        gnt_d      = owner_oh;
      end
      ARB_WAIT: begin
        addr_out_d = win_addr_q;
        src_id_d   = win_id_q;
        if (done_in) begin
          state_d = ARB_DONE;
          ack_d   = owner_oh;
        end else begin
          cmd_out_d = win_cmd_q;
          gnt_d     = owner_oh;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      win_cmd_q  <= No_OP;
      win_addr_q <= '0;
      win_id_q   <= '0;
      cmd_out    <= No_OP;
      addr_out   <= '0;
      src_id     <= '0;
      bus_valid  <= 1'b0;
      gnt        <= '0;
      ack        <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cmd_q  <= win_cmd_d;
      win_addr_q <= win_addr_d;
      win_id_q   <= win_id_d;
      cmd_out    <= cmd_out_d;
      addr_out   <= addr_out_d;
      src_id     <= src_id_d;
      bus_valid  <= bus_valid_d;
      gnt        <= gnt_d;
      ack        <= ack_d;
      busy       <= busy_d;
    end
  end

endmodule
